counter_bank: RTL

Multi-channel event counter bank for the shared statistics path: `NUM_CH` independent up/down counters with per-channel sync clear, selectable saturate or wrap arithmetic, and programmable increment step. Each counter has a sticky overflow/underflow flag and a programmable threshold alarm. A single-entry valid/ready read port returns any channel's value. Instantiated wherever datapath blocks need several counters (queue occupancy, drops, credits) behind one readout.

---
 rtl/counter_bank_pkg.sv | 19 +
 rtl/counter_lane.sv | 103 ++++++++++
 rtl/counter_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the multi-channel event counter bank.
// Channel-select width, arithmetic mode constants and max-value helper.
package counter_bank_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] max_val(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_lane.sv
// One counter channel: up/down count with step, sticky overflow,
// threshold register and sticky threshold alarm.
module counter_lane
    import counter_bank_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter longint unsigned STEP     = 1,
    parameter int              SATURATE = MODE_SAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             thr_we,
    input  logic [WIDTH-1:0] thr_data,
    input  logic             alarm_clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             alarm
);

    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(max_val(WIDTH));

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] thr_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_d;
    logic             alarm_d;
    logic             alarm_hit;
    logic             do_inc;
    logic             do_dec;

    // Extra top bit carries the carry/borrow used for overflow detect.
    assign sum    = {1'b0, count} + STEP_W;
    assign diff   = {1'b0, count} - STEP_W;
    assign do_inc = ~clr & inc & ~dec;
    assign do_dec = ~clr & dec & ~inc;

    always_comb begin
        count_d = count;
        ovf_d   = ovf;
        unique case (1'b1)
            clr: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            do_inc: begin
                count_d = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        count_d = CNT_MAX;
                    end
                end
            end
            do_dec: begin
                count_d = diff[WIDTH-1:0];
                if (diff[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        count_d = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Compare uses registered count and threshold, so alarm trails by one.
    assign alarm_hit = (thr_q != '0) && (count >= thr_q);

    always_comb begin
        alarm_d = alarm;
        if (clr) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            alarm <= 1'b0;
            thr_q <= '0;
        end else begin
            count <= count_d;
            ovf   <= ovf_d;
            alarm <= alarm_d;
            if (thr_we) begin
                thr_q <= thr_data;
            end
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH counter lanes with threshold write decode and a
// single-entry valid/ready read port returning any channel's count.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int              NUM_CH   = 8,
    parameter int              WIDTH    = 32,
    parameter longint unsigned STEP     = 1,
    parameter int              SATURATE = MODE_SAT,
    localparam int             CH_W     = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] inc_in,
    input  logic [NUM_CH-1:0] dec_in,
    input  logic [NUM_CH-1:0] clr_in,
    input  logic              thr_wr_en,
    input  logic [CH_W-1:0]   thr_sel,
    input  logic [WIDTH-1:0]  thr_data,
    input  logic [NUM_CH-1:0] alarm_clr_in,
    output logic [NUM_CH-1:0] alarm_out,
    output logic [NUM_CH-1:0] ovf_out,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [WIDTH-1:0]  rd_resp_data
);

    logic [NUM_CH-1:0][WIDTH-1:0] counts;
    logic [WIDTH-1:0]             rd_mux;
    logic                         rd_accept;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic lane_thr_we;

        assign lane_thr_we = thr_wr_en & (thr_sel == CH_W'(i));

        counter_lane #(
            .WIDTH    (WIDTH),
            .STEP     (STEP),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_in[i]),
            .dec       (dec_in[i]),
            .clr       (clr_in[i]),
            .thr_we    (lane_thr_we),
            .thr_data  (thr_data),
            .alarm_clr (alarm_clr_in[i]),
            .count     (counts[i]),
            .ovf       (ovf_out[i]),
            .alarm     (alarm_out[i])
        );
    end

    // Out-of-range channels match no lane and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_mux = counts[i];
            end
        end
    end

    assign rd_req_ready = ~rd_resp_valid | rd_resp_ready;
    assign rd_accept    = rd_req_valid & rd_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else if (rd_accept) begin
            rd_resp_valid <= 1'b1;
            rd_resp_data  <= rd_mux;
        end else if (rd_resp_ready) begin
            rd_resp_valid <= 1'b0;
        end
    end

endmodule
